// File: rtl/tcm_arb_pkg.sv
// Shared types for the TCM data-port arbiter: FSM states, owner IDs, data width.
package tcm_arb_pkg;

    localparam int TCM_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RUN   = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_SPI  = 1'b0,
        OWN_CORE = 1'b1
    } owner_t;

endpackage

// File: rtl/tcm_arb_owner_fifo.sv
// In-order 1-bit owner FIFO; remembers which requester issued each accepted TCM request.
module tcm_arb_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    // Full/empty are registered views, so a push in a full cycle is refused even if a pop frees a slot.
    assign full_o  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= din_i;
    end

endmodule

// File: rtl/tcm_dport_arbiter.sv
// Shares the TCM data port between the SPI loader (BOOT) and the core (RUN).
// Define TCMARB_RR_EN for round-robin arbitration in RUN; default is fixed SPI > core.
module tcm_dport_arbiter
    import tcm_arb_pkg::*;
#(
    parameter int OUTSTANDING = 2,
    parameter int TAG_W       = 11
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [TCM_DATA_W-1:0] spi_addr_i,
    input  logic [TCM_DATA_W-1:0] spi_data_wr_i,
    input  logic                  spi_rd_i,
    input  logic [3:0]            spi_wr_i,
    output logic                  spi_accept_o,
    output logic                  spi_ack_o,
    output logic [TCM_DATA_W-1:0] spi_data_rd_o,
    input  logic                  spi_boot_done_i,
    input  logic [TCM_DATA_W-1:0] core_addr_i,
    input  logic [TCM_DATA_W-1:0] core_data_wr_i,
    input  logic                  core_rd_i,
    input  logic [3:0]            core_wr_i,
    input  logic [TAG_W-1:0]      core_req_tag_i,
    output logic                  core_accept_o,
    output logic                  core_ack_o,
    output logic                  core_error_o,
    output logic [TCM_DATA_W-1:0] core_data_rd_o,
    output logic [TAG_W-1:0]      core_resp_tag_o,
    output logic                  core_hold_o,
    output logic [TCM_DATA_W-1:0] mem_addr_o,
    output logic [TCM_DATA_W-1:0] mem_data_wr_o,
    output logic                  mem_rd_o,
    output logic [3:0]            mem_wr_o,
    output logic [TAG_W-1:0]      mem_req_tag_o,
    input  logic                  mem_accept_i,
    input  logic                  mem_ack_i,
    input  logic                  mem_error_i,
    input  logic [TCM_DATA_W-1:0] mem_data_rd_i,
    input  logic [TAG_W-1:0]      mem_resp_tag_i,
    output logic                  proto_err_o
);
    arb_state_t r_state;
    logic       r_proto_err;
    logic       w_spi_vld, w_core_vld;
    logic       w_spi_ok, w_core_ok;
    logic       w_spi_gnt, w_core_gnt;
    logic       w_full, w_empty, w_head;
    logic       w_push, w_pop;

    assign w_spi_vld  = spi_rd_i | (|spi_wr_i);
    assign w_core_vld = core_rd_i | (|core_wr_i);
    assign w_spi_ok   = w_spi_vld & ~w_full & ((r_state == ST_BOOT) | (r_state == ST_RUN));
    assign w_core_ok  = w_core_vld & ~w_full & (r_state == ST_RUN);

`ifdef TCMARB_RR_EN
    owner_t r_last;

    // On a tie the requester that did not win last time gets the port.
    assign w_spi_gnt = w_spi_ok & (~w_core_ok | (r_last == OWN_CORE));

    always_ff @(posedge clk_i) begin
        if (rst_i)       r_last <= OWN_CORE;
        else if (w_push) r_last <= w_core_gnt ? OWN_CORE : OWN_SPI;
    end
`else
    assign w_spi_gnt = w_spi_ok;
`endif
    assign w_core_gnt = w_core_ok & ~w_spi_gnt;

    always_comb begin
        mem_rd_o      = 1'b0;
        mem_wr_o      = 4'h0;
        mem_addr_o    = '0;
        mem_data_wr_o = '0;
        mem_req_tag_o = '0;
        if (w_spi_gnt) begin
            mem_rd_o      = spi_rd_i;
            mem_wr_o      = spi_wr_i;
            mem_addr_o    = spi_addr_i;
            mem_data_wr_o = spi_data_wr_i;
        end else if (w_core_gnt) begin
            mem_rd_o      = core_rd_i;
            mem_wr_o      = core_wr_i;
            mem_addr_o    = core_addr_i;
            mem_data_wr_o = core_data_wr_i;
            mem_req_tag_o = core_req_tag_i;
        end
    end

    assign spi_accept_o  = mem_accept_i & w_spi_gnt;
    assign core_accept_o = mem_accept_i & w_core_gnt;
    assign w_push        = (mem_rd_o | (|mem_wr_o)) & mem_accept_i;
    assign w_pop         = mem_ack_i & ~w_empty;

    tcm_arb_owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_core_gnt),
        .full_o  (w_full),
        .empty_o (w_empty),
        .head_o  (w_head)
    );

    // Response data fans out unconditionally; only the acks follow the owner at the FIFO head.
    assign spi_ack_o       = w_pop & (w_head == OWN_SPI);
    assign core_ack_o      = w_pop & (w_head == OWN_CORE);
    assign core_error_o    = w_pop & (w_head == OWN_CORE) & mem_error_i;
    assign spi_data_rd_o   = mem_data_rd_i;
    assign core_data_rd_o  = mem_data_rd_i;
    assign core_resp_tag_o = mem_resp_tag_i;
    assign core_hold_o     = (r_state != ST_RUN);
    assign proto_err_o     = r_proto_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_BOOT;
            r_proto_err <= 1'b0;
        end else begin
            if (mem_ack_i & w_empty) r_proto_err <= 1'b1;
            case (r_state)
                ST_BOOT:  if (spi_boot_done_i) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_empty)         r_state <= ST_RUN;
                ST_RUN:                        r_state <= ST_RUN;
                default:                       r_state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_tcm_dport_arbiter.sv
// Self-checking bench for tcm_dport_arbiter: directed table, hand sequences, random traffic vs a queue model.
module tb_tcm_dport_arbiter;
    localparam int OUTSTANDING = 2;
    localparam int TAG_W       = 11;
`ifdef TCMARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int M_BOOT = 0, M_DRAIN = 1, M_RUN = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       spi_addr_i = '0, spi_data_wr_i = '0;
    logic              spi_rd_i = 1'b0;
    logic [3:0]        spi_wr_i = '0;
    logic              spi_accept_o, spi_ack_o;
    logic [31:0]       spi_data_rd_o;
    logic              spi_boot_done_i = 1'b0;
    logic [31:0]       core_addr_i = '0, core_data_wr_i = '0;
    logic              core_rd_i = 1'b0;
    logic [3:0]        core_wr_i = '0;
    logic [TAG_W-1:0]  core_req_tag_i = '0;
    logic              core_accept_o, core_ack_o, core_error_o;
    logic [31:0]       core_data_rd_o;
    logic [TAG_W-1:0]  core_resp_tag_o;
    logic              core_hold_o;
    logic [31:0]       mem_addr_o, mem_data_wr_o;
    logic              mem_rd_o;
    logic [3:0]        mem_wr_o;
    logic [TAG_W-1:0]  mem_req_tag_o;
    logic              mem_accept_i = 1'b0, mem_ack_i = 1'b0, mem_error_i = 1'b0;
    logic [31:0]       mem_data_rd_i = '0;
    logic [TAG_W-1:0]  mem_resp_tag_i = '0;
    logic              proto_err_o;

    int checks = 0;
    int errors = 0;

    int m_state;
    bit m_q[$];
    bit m_last;
    bit m_perr;
    int m_mask;
    bit e_spi_g, e_core_g;

    always #5 clk = ~clk;

    tcm_dport_arbiter #(.OUTSTANDING(OUTSTANDING), .TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .spi_addr_i(spi_addr_i), .spi_data_wr_i(spi_data_wr_i), .spi_rd_i(spi_rd_i), .spi_wr_i(spi_wr_i),
        .spi_accept_o(spi_accept_o), .spi_ack_o(spi_ack_o), .spi_data_rd_o(spi_data_rd_o),
        .spi_boot_done_i(spi_boot_done_i),
        .core_addr_i(core_addr_i), .core_data_wr_i(core_data_wr_i), .core_rd_i(core_rd_i), .core_wr_i(core_wr_i),
        .core_req_tag_i(core_req_tag_i), .core_accept_o(core_accept_o), .core_ack_o(core_ack_o),
        .core_error_o(core_error_o), .core_data_rd_o(core_data_rd_o), .core_resp_tag_o(core_resp_tag_o),
        .core_hold_o(core_hold_o),
        .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .mem_req_tag_o(mem_req_tag_o), .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i),
        .mem_error_i(mem_error_i), .mem_data_rd_i(mem_data_rd_i), .mem_resp_tag_i(mem_resp_tag_i),
        .proto_err_o(proto_err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit srd, input bit [3:0] swr, input logic [31:0] sa, input bit crd,
                         input bit [3:0] cwr, input bit acc, input bit ack, input bit done);
        spi_rd_i        = srd;
        spi_wr_i        = swr;
        spi_addr_i      = sa;
        spi_data_wr_i   = $urandom;
        core_rd_i       = crd;
        core_wr_i       = cwr;
        core_addr_i     = 32'h10;
        core_data_wr_i  = $urandom;
        core_req_tag_i  = TAG_W'($urandom);
        mem_accept_i    = acc;
        mem_ack_i       = ack;
        mem_error_i     = 1'($urandom_range(0, 1));
        mem_data_rd_i   = $urandom;
        mem_resp_tag_i  = TAG_W'($urandom);
        spi_boot_done_i = done;
    endtask

    // Reference: who may win this cycle follows from the phase, FIFO occupancy and policy.
    task automatic model_check();
        bit full, sv, cv, ack_ok, own;
        logic erd;
        logic [3:0] ewr;
        logic [31:0] ea, ed;
        logic [TAG_W-1:0] et;
        full = (m_q.size() == OUTSTANDING);
        sv = spi_rd_i | (|spi_wr_i);
        cv = core_rd_i | (|core_wr_i);
        e_spi_g = 1'b0;
        e_core_g = 1'b0;
        if (!full) begin
            if (m_state == M_BOOT) e_spi_g = sv;
            else if (m_state == M_RUN) begin
                if (sv && cv) begin
                    e_spi_g = RR ? m_last : 1'b1;
                    e_core_g = !e_spi_g;
                end else begin
                    e_spi_g = sv;
                    e_core_g = cv;
                end
            end
        end
        erd = 1'b0; ewr = 4'h0; ea = '0; ed = '0; et = '0;
        if (e_spi_g) begin
            erd = spi_rd_i; ewr = spi_wr_i; ea = spi_addr_i; ed = spi_data_wr_i;
        end else if (e_core_g) begin
            erd = core_rd_i; ewr = core_wr_i; ea = core_addr_i; ed = core_data_wr_i; et = core_req_tag_i;
        end
        chk("mem_strobe", {mem_rd_o, mem_wr_o}, {erd, ewr});
        chk("mem_addr", mem_addr_o, ea);
        chk("mem_wdata", mem_data_wr_o, ed);
        chk("mem_tag", mem_req_tag_o, et);
        chk("accept", {spi_accept_o, core_accept_o}, {mem_accept_i & e_spi_g, mem_accept_i & e_core_g});
        ack_ok = mem_ack_i && (m_q.size() > 0);
        own = ack_ok ? m_q[0] : 1'b0;
        chk("ack", {spi_ack_o, core_ack_o, core_error_o},
            {ack_ok & !own, ack_ok & own, ack_ok & own & mem_error_i});
        chk("hold", core_hold_o, m_state != M_RUN);
        if (m_mask == 0) chk("proto_err", proto_err_o, m_perr);
        chk("rdata", {spi_data_rd_o, core_data_rd_o}, {mem_data_rd_i, mem_data_rd_i});
        chk("resp_tag", core_resp_tag_o, mem_resp_tag_i);
    endtask

    task automatic model_update();
        bit was_empty;
        if (rst) begin
            m_state = M_BOOT;
            m_q.delete();
            m_perr = 1'b0;
            m_last = 1'b1;
            m_mask = 2;
        end else begin
            was_empty = (m_q.size() == 0);
            if (mem_ack_i) begin
                if (was_empty) m_perr = 1'b1;
                else void'(m_q.pop_front());
            end
            if (mem_accept_i && (e_spi_g || e_core_g)) begin
                m_q.push_back(e_core_g);
                m_last = e_core_g;
            end
            if (m_state == M_BOOT && spi_boot_done_i) m_state = M_DRAIN;
            else if (m_state == M_DRAIN && was_empty) m_state = M_RUN;
            if (m_mask > 0) m_mask--;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step_exp(input bit sacc, input bit cacc, input bit sack, input bit cack, input bit hold);
        @(negedge clk);
        model_check();
        chk("t_spi_accept", spi_accept_o, sacc);
        chk("t_core_accept", core_accept_o, cacc);
        chk("t_spi_ack", spi_ack_o, sack);
        chk("t_core_ack", core_ack_o, cack);
        chk("t_core_hold", core_hold_o, hold);
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        bit srd; bit [3:0] swr; logic [31:0] sa; bit acc; bit ack; bit done;
        bit e_sacc; bit e_cacc; bit e_sack; bit e_cack; bit e_hold;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // BOOT exclusivity, then boot_done with one SPI request in flight (DRAIN wait).
        tbl[0] = '{1'b0, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 4'hF, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 4'hF, 32'h8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 4'h0, 32'hC, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 4'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        @(posedge clk);
        #1;
        m_state = M_BOOT; m_q.delete(); m_perr = 1'b0; m_last = 1'b1; m_mask = 0;
        tick();
        chk("rst_hold", core_hold_o, 1'b1);
        chk("rst_proto", proto_err_o, 1'b0);
        chk("rst_strobes", {mem_rd_o, mem_wr_o, spi_accept_o, core_accept_o, spi_ack_o, core_ack_o}, '0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].srd, tbl[i].swr, tbl[i].sa, 1'b1, 4'h0, tbl[i].acc, tbl[i].ack, tbl[i].done);
            step_exp(tbl[i].e_sacc, tbl[i].e_cacc, tbl[i].e_sack, tbl[i].e_cack, tbl[i].e_hold);
        end

        // Random RUN traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, $urandom,
                  ($urandom_range(0, 1) == 0), ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0,
                  ($urandom_range(0, 3) != 0), (m_q.size() > 0) && ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 15) == 0));
            tick();
        end

        for (int g = 0; g < 8 && m_q.size() > 0; g++) begin
            drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        chk("drained", m_q.size() == 0, 1'b1);

        // Back-pressure: third request blocked, accept resumes the cycle after the first ack.
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0); step_exp(0, 1, 0, 0, 0);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0); step_exp(0, 1, 0, 0, 0);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0); step_exp(0, 0, 0, 0, 0);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0); step_exp(0, 0, 0, 1, 0);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0); step_exp(0, 1, 0, 0, 0);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0); step_exp(0, 0, 0, 1, 0);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0); step_exp(0, 0, 0, 1, 0);

        // Orphan ack: nothing forwarded, sticky error flag.
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0); step_exp(0, 0, 0, 0, 0);
        chk("orphan_set", proto_err_o, 1'b1);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0); tick();
        chk("orphan_sticky", proto_err_o, 1'b1);

        // Reset with two requests outstanding.
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0); tick();
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0); tick();
        rst = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0); tick();
        rst = 1'b0;
        chk("rst_mid_proto", proto_err_o, 1'b0);
        drive(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0); step_exp(0, 0, 0, 0, 1);

        // Into RUN with an empty FIFO, then six cycles of contention.
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1); step_exp(0, 0, 0, 0, 1);
        drive(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0); step_exp(0, 0, 0, 0, 1);
        begin
            bit prev_spi;
            bit eg;
            prev_spi = 1'b0;
            for (int i = 0; i < 6; i++) begin
                eg = RR ? ((i % 2) == 0) : 1'b1;
                drive(1'b0, 4'hF, 32'h100 + 32'(i * 4), 1'b1, 4'h0, 1'b1, (i > 0), 1'b0);
                step_exp(eg, !eg, (i > 0) && prev_spi, (i > 0) && !prev_spi, 1'b0);
                prev_spi = eg;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcm_dport_arbiter.md
# tcm_dport_arbiter

Shares the TCM data port (`tcm_mem` `mem_d_*`) between the SPI loader (`slave_spi` memory-master side) and the core data/LSU port, replacing the static `spi_used` mux. A BOOT phase gives the SPI loader exclusive access and holds the core. A RUN phase arbitrates per cycle. Responses are routed back to the issuing requester through an in-order owner FIFO.

## Interface
- `OUTSTANDING`, default 2: maximum accepted-but-unacknowledged requests (owner FIFO depth, power of two ≥ 2).
- `TAG_W`, default 11: width of the core request/response tag.
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `spi_addr_i`, `spi_data_wr_i`  in  32 each  SPI request address and write data.
- `spi_rd_i`  in  1 / `spi_wr_i`  in  4  SPI read strobe / byte-write enables.
- `spi_accept_o`, `spi_ack_o`  out  1 each  SPI request accepted / response valid.
- `spi_data_rd_o`  out  32  SPI read data.
- `spi_boot_done_i`  in  1  one-cycle pulse: the loader has finished.
- `core_addr_i`, `core_data_wr_i`  in  32 each  core request address and write data.
- `core_rd_i`  in  1 / `core_wr_i`  in  4  core read strobe / byte-write enables.
- `core_req_tag_i`  in  TAG_W  core request tag.
- `core_accept_o`, `core_ack_o`, `core_error_o`  out  1 each  core accept / response valid / response error.
- `core_data_rd_o`  out  32  core read data.
- `core_resp_tag_o`  out  TAG_W  core response tag.
- `core_hold_o`  out  1  holds the core in reset/stall while in BOOT.
- `mem_addr_o`, `mem_data_wr_o`  out  32 each  to TCM.
- `mem_rd_o`  out  1 / `mem_wr_o`  out  4  to TCM.
- `mem_req_tag_o`  out  TAG_W  to TCM.
- `mem_accept_i`, `mem_ack_i`, `mem_error_i`  in  1 each  from TCM.
- `mem_data_rd_i`  in  32 / `mem_resp_tag_i`  in  TAG_W  from TCM.
- `proto_err_o`  out  1  sticky flag: `mem_ack_i` arrived while the owner FIFO was empty.

## Operation
- **Request valid.** A requester is valid when `rd | (|wr)`.
- **FSM states.** BOOT (reset state), DRAIN, RUN.
  - BOOT: only SPI can be granted; `core_hold_o`=1. On `spi_boot_done_i` go to DRAIN.
  - DRAIN: no new grants. Go to RUN when the owner FIFO is empty.
  - RUN: both requesters are eligible; `core_hold_o`=0. RUN is left only by reset.
- **Grant.** Combinational and single-winner.
  - A grant requires: the requester is valid, it is eligible in the current state, and the owner FIFO is not full.
  - RUN default policy: fixed priority, SPI > core.
- **Request forwarding.**
  - The winner's request drives `mem_*_o`.
  - With no winner, `mem_rd_o`=0, `mem_wr_o`=0, and address/data/tag are don't-care (driven 0).
  - `mem_req_tag_o` carries `core_req_tag_i` for a core grant and 0 for an SPI grant.
- **Accept.** `<winner>_accept_o = mem_accept_i & grant`. The loser's accept is 0, so it must hold its request stable until accepted.
- **Owner FIFO push/pop.**
  - Push: on `mem_rd_o|(|mem_wr_o)` & `mem_accept_i`, push the owner ID (0 = SPI, 1 = core).
  - Pop: on `mem_ack_i`, pop the head and route the ack to its owner. Push and pop in the same cycle are both honoured, and occupancy is unchanged.
  - `mem_error_i` routes to `core_error_o` only when the head owner is core; SPI errors are dropped.
- **Response data.** `mem_data_rd_i` fans out to both `*_data_rd_o`; `mem_resp_tag_i` goes to `core_resp_tag_o`. Only the `*_ack_o` outputs are gated by owner.
- **Ack with empty FIFO.** No ack is forwarded, and `proto_err_o` is set and stays set until reset.
- **Occupancy counter.** Width is `$clog2(OUTSTANDING)+1`. The pointers wrap modulo `OUTSTANDING`.

## Timing
- **Reset values.** State = BOOT, FIFO empty, `core_hold_o`=1, `proto_err_o`=0. All acks, accepts and `mem` strobes are 0.
- **Grant/accept latency.** Zero cycles: combinational from requests, `mem_accept_i` and the registered FIFO-full flag.
- **Ack latency.** Zero cycles: combinational from `mem_ack_i` and the registered FIFO head.
- **Full FIFO.** A push is blocked when the FIFO is full at the start of the cycle, even if a pop happens in the same cycle.
- **`core_hold_o` release.** Deasserts on the clock edge that enters RUN.
- **`spi_boot_done_i` outside BOOT.** Ignored.
- **Reset mid-transaction.** The FIFO is flushed and any TCM acks still in flight are treated as orphans. `proto_err_o` may set on them; the bench masks the first 2 cycles after reset.

## Configuration
- `TCMARB_RR_EN` defined: the RUN policy is round-robin. A 1-bit last-winner register is updated on each accepted grant; when both requesters are valid, the one that was not last granted wins. The register resets to core, so SPI wins the first tie.
- `TCMARB_RR_EN` undefined: the RUN policy is fixed SPI > core, and the last-winner register is not present.
- BOOT and DRAIN behaviour is identical in both builds.

## Structure
- Package `tcm_arb_pkg`:
  - `arb_state_t` enum (BOOT, DRAIN, RUN).
  - `owner_t` (OWN_SPI = 0, OWN_CORE = 1).
  - `TCM_DATA_W` = 32.
- Sub-module `tcm_arb_owner_fifo`: a parameterised-depth 1-bit FIFO with push, pop, full, empty and head ports.
- FSM, grant logic and muxing live in the top module.

## Test plan
- **BOOT exclusivity.** Drive SPI writes to 0x0, 0x4 and 0x8 while the core requests a read of 0x10 → exactly 3 SPI accepts and acks, `core_accept_o`=0 throughout, `core_hold_o`=1.
- **DRAIN wait.** Pulse `spi_boot_done_i` while 1 SPI request is unacked → state stays DRAIN until that ack; `core_hold_o` falls on the following edge.
- **RUN contention, fixed priority.** SPI and core both request every cycle → every grant goes to SPI; the core is granted only in cycles where SPI is idle. Ack routing follows the push order.
- **Back-pressure.** `mem_ack_i` held low with `OUTSTANDING`=2 → the 3rd request is not accepted. The first ack then allows the next accept one cycle later.
- **Orphan ack and reset.** `mem_ack_i` with an empty FIFO → no `*_ack_o`, and `proto_err_o`=1 until reset. Reset asserted with 2 requests outstanding → FIFO empty, state BOOT, `core_hold_o`=1.
- **`TCMARB_RR_EN` build.** Both requesters valid for 6 cycles in RUN → grants alternate SPI, core, SPI, core, SPI, core.
